// File: rtl/goose_pkg.sv
// goose_pkg: shared obstacle types, geometry, colours and LFSR taps for the runner game
package goose_pkg;
  typedef enum logic {FLOOR = 1'b0, FLYING = 1'b1} obj_type_e;
  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} field_state_e;
  localparam int GROUND_Y = 400;
  localparam int FLY_Y = 330;
  localparam int OBJ_W = 20;
  localparam int OBJ_H = 30;
  localparam logic [11:0] COL_FLOOR = 12'h0A0;
  localparam logic [11:0] COL_FLY = 12'hA50;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/obstacle_lfsr.sv
// obstacle_lfsr: 16-bit Galois LFSR (taps 16,14,13,11) with seed and enable
module obstacle_lfsr
  import goose_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_rand,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] lfsr
);
  always_ff @(posedge clk_rand)
    if (reset) lfsr <= SEED;
    else if (en) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/obstacle_field.sv
// obstacle_field: scrolling obstacle slots with LFSR-spaced spawns and a registered per-pixel hit query.
// Define OBSTACLE_FLYING_EN to give each spawn a random floor/flying type.
module obstacle_field #(
  parameter int          N_SLOTS     = 4,
  parameter int          XW          = 12,
  parameter int          SHIFT       = 5,
  parameter int          SPAWN_X     = 660,
  parameter int          OBJ_W       = goose_pkg::OBJ_W,
  parameter int          OBJ_H       = goose_pkg::OBJ_H,
  parameter int          GROUND_Y    = goose_pkg::GROUND_Y,
  parameter int          FLY_Y       = goose_pkg::FLY_Y,
  parameter int          GAP_START   = 400,
  parameter int          GAP_FLOOR   = 150,
  parameter int          RANGE_START = 150,
  parameter int          RANGE_FLOOR = 25,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [11:0] COL_FLOOR   = goose_pkg::COL_FLOOR,
  parameter logic [11:0] COL_FLY     = goose_pkg::COL_FLY
) (
  input  logic        clk_rand,
  input  logic        reset,
  input  logic        tick,
  input  logic        freeze,
  input  logic [15:0] score,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  output logic        obj_px,
  output logic [11:0] obj_rgb,
  output logic        frozen,
  output logic [3:0]  active_cnt
);
  import goose_pkg::*;
  localparam int IW = $clog2(N_SLOTS);
  typedef logic signed [XW:0] ext_t;
  localparam ext_t SH = ext_t'(SHIFT);
  localparam ext_t SX = ext_t'(SPAWN_X);
  localparam ext_t OW = ext_t'(OBJ_W);
  localparam ext_t XMIN = ext_t'(-(2 ** (XW - 1)));
  localparam logic [9:0] GB = 10'(GROUND_Y);
  localparam logic [9:0] GT = 10'(GROUND_Y - OBJ_H);
  field_state_e state, state_n;
  logic [N_SLOTS-1:0] active, keep, in_x, in_y;
  logic signed [XW-1:0] pos [N_SLOTS];
  logic signed [XW-1:0] last_pos;
  ext_t moved [N_SLOTS];
  ext_t last_dec, last_mv, pxe;
  logic [11:0] col [N_SLOTS];
  logic [9:0] next_gap, min_gap, min_new, gap_new;
  logic [7:0] range, range_new;
  logic [15:0] lfsr, prod;
  logic [16:0] diff;
  logic [IW-1:0] free_idx;
  logic [11:0] hit_rgb;
  logic tick_par, has_free, run_tick, spawn, hit, floor_band, unused_ok;
`ifdef OBSTACLE_FLYING_EN
  localparam logic [9:0] FB = 10'(FLY_Y);
  localparam logic [9:0] FT = 10'(FLY_Y - OBJ_H);
  logic [N_SLOTS-1:0] typ;
  logic fly_band;
  assign fly_band = py > FT && py <= FB;
`endif
  obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_rand(clk_rand),
    .reset(reset),
    .en(1'b1),
    .lfsr(lfsr)
  );
  always_ff @(posedge clk_rand) state <= reset ? RUN : state_n;
  always_comb state_n = (state == RUN && freeze) ? FROZEN : state;
  assign frozen = state == FROZEN;
  assign active_cnt = 4'($countones(active));
  assign run_tick = state == RUN && !freeze && tick;
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (!active[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    for (int i = 0; i < N_SLOTS; i++) begin
      moved[i] = ext_t'(pos[i]) - SH;
      keep[i] = moved[i] >= -OW;
    end
  end
  // last_pos saturates so a long deferral cannot wrap it back to a large positive x
  assign last_dec = ext_t'(last_pos) - SH;
  assign last_mv = last_dec < XMIN ? XMIN : last_dec;
  assign diff = 17'(GAP_START) - {1'b0, score};
  assign min_new = (diff[16] || diff[15:0] < 16'(GAP_FLOOR)) ? 10'(GAP_FLOOR) : diff[9:0];
  assign range_new = (tick_par && range > 8'(RANGE_FLOOR)) ? range - 8'd1 : range;
  assign prod = lfsr[15:8] * range_new;
  assign gap_new = min_new + {2'b0, prod[15:8]};
  assign spawn = has_free && (SX - last_mv >= ext_t'({1'b0, next_gap}));
  assign unused_ok = ^{lfsr[7:0], prod[7:0], last_mv[XW], min_gap};
  assign pxe = ext_t'({1'b0, px});
  assign floor_band = py > GT && py <= GB;
  always_comb begin
    hit = 1'b0;
    hit_rgb = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      in_x[i] = pxe >= ext_t'(pos[i]) && pxe < ext_t'(pos[i]) + OW;
`ifdef OBSTACLE_FLYING_EN
      in_y[i] = obj_type_e'(typ[i]) == FLYING ? fly_band : floor_band;
      col[i] = obj_type_e'(typ[i]) == FLYING ? COL_FLY : COL_FLOOR;
`else
      in_y[i] = floor_band;
      col[i] = COL_FLOOR;
`endif
    end
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (active[i] && in_x[i] && in_y[i]) begin
        hit = 1'b1;
        hit_rgb = col[i];
      end
  end
  always_ff @(posedge clk_rand) begin
    if (reset) begin
      active <= N_SLOTS'(1);
      for (int i = 0; i < N_SLOTS; i++) pos[i] <= XW'(SPAWN_X);
      last_pos <= XW'(SPAWN_X);
      next_gap <= 10'(GAP_START);
      min_gap <= 10'(GAP_START);
      range <= 8'(RANGE_START);
      tick_par <= 1'b0;
`ifdef OBSTACLE_FLYING_EN
      typ <= '0;
`endif
      obj_px <= 1'b0;
      obj_rgb <= '0;
    end else begin
      obj_px <= hit;
      obj_rgb <= hit_rgb;
      if (run_tick) begin
        for (int i = 0; i < N_SLOTS; i++) begin
          if (active[i]) pos[i] <= moved[i][XW-1:0];
          active[i] <= active[i] && keep[i];
        end
        last_pos <= last_mv[XW-1:0];
        min_gap <= min_new;
        range <= range_new;
        tick_par <= ~tick_par;
        if (spawn) begin
          active[free_idx] <= 1'b1;
          pos[free_idx] <= XW'(SPAWN_X);
`ifdef OBSTACLE_FLYING_EN
          typ[free_idx] <= lfsr[0];
`endif
          last_pos <= XW'(SPAWN_X);
          next_gap <= gap_new;
        end
      end
    end
  end
endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: randomized bench checking obstacle_field against a behavioural slot model
module tb_obstacle_field;
  localparam int NS = 4;
  logic clk_rand = 1'b0, reset = 1'b1, tick = 1'b0, freeze = 1'b0;
  logic [15:0] score = '0;
  logic [9:0] px = '0, py = '0;
  logic obj_px, frozen;
  logic [11:0] obj_rgb;
  logic [3:0] active_cnt;
  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;
  int m_act[NS], m_pos[NS], m_typ[NS];
  int m_last, m_gap, m_rng, m_par, m_lfsr, m_frz;
  int e_px, e_rgb, e_frz, e_cnt;

  obstacle_field dut (
    .clk_rand(clk_rand),
    .reset(reset),
    .tick(tick),
    .freeze(freeze),
    .score(score),
    .px(px),
    .py(py),
    .obj_px(obj_px),
    .obj_rgb(obj_rgb),
    .frozen(frozen),
    .active_cnt(active_cnt)
  );

  always #5 clk_rand = ~clk_rand;

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk_rand)
    if (chk_en) begin
      check("obj_px", int'(obj_px), e_px);
      check("obj_rgb", int'(obj_rgb), e_rgb);
      check("frozen", int'(frozen), e_frz);
      check("active_cnt", int'(active_cnt), e_cnt);
    end

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = (i == 0);
      m_pos[i] = 660;
      m_typ[i] = 0;
    end
    m_last = 660;
    m_gap = 400;
    m_rng = 150;
    m_par = 0;
    m_lfsr = 'hACE1;
    m_frz = 0;
  endtask

  task automatic m_tick(int cur, int sc);
    int fr = -1;
    int mg;
    for (int i = NS - 1; i >= 0; i--) if (m_act[i] == 0) fr = i;
    for (int i = 0; i < NS; i++)
      if (m_act[i] != 0) begin
        m_pos[i] -= 5;
        if (m_pos[i] < -20) m_act[i] = 0;
      end
    m_last -= 5;
    mg = 400 - sc;
    if (mg < 150) mg = 150;
    if (m_par != 0 && m_rng > 25) m_rng--;
    m_par = 1 - m_par;
    if (660 - m_last >= m_gap && fr >= 0) begin
      m_act[fr] = 1;
      m_pos[fr] = 660;
`ifdef OBSTACLE_FLYING_EN
      m_typ[fr] = cur & 1;
`else
      m_typ[fr] = 0;
`endif
      m_last = 660;
      m_gap = mg + (((cur >> 8) & 255) * m_rng) / 256;
    end
  endtask

  task automatic cycle(bit r, bit t, bit f, int sc, int qx, int qy);
    int cur, bot;
    @(negedge clk_rand);
    #1;
    reset = r;
    tick = t;
    freeze = f;
    score = 16'(sc);
    px = 10'(qx);
    py = 10'(qy);
    e_px = 0;
    e_rgb = 0;
    if (r) m_reset();
    else begin
      for (int i = NS - 1; i >= 0; i--) begin
        bot = m_typ[i] != 0 ? 330 : 400;
        if (m_act[i] != 0 && qx >= m_pos[i] && qx < m_pos[i] + 20 && qy > bot - 30 && qy <= bot) begin
          e_px = 1;
          e_rgb = m_typ[i] != 0 ? 'hA50 : 'h0A0;
        end
      end
      cur = m_lfsr;
      m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr & 1) != 0 ? 'hB400 : 0);
      if (m_frz == 0) begin
        if (f) m_frz = 1;
        else if (t) m_tick(cur, sc);
      end
    end
    e_frz = m_frz;
    e_cnt = 0;
    for (int i = 0; i < NS; i++) e_cnt += m_act[i];
  endtask

  task automatic pick(output int qx, output int qy);
    int k;
    int offs[4] = '{-1, 0, 19, 20};
    int ys[8] = '{370, 371, 400, 401, 300, 301, 330, 331};
    k = $urandom_range(0, NS - 1);
    if ($urandom_range(0, 3) != 0 && m_act[k] != 0) qx = m_pos[k] + offs[$urandom_range(0, 3)];
    else qx = $urandom_range(0, 1023);
    if (qx < 0 || qx > 1023) qx = $urandom_range(0, 1023);
    qy = $urandom_range(0, 1) != 0 ? ys[$urandom_range(0, 7)] : $urandom_range(0, 1023);
  endtask

  task automatic run_random(int n, int sc_lo, int sc_hi, int frz_odds);
    int qx, qy, sc;
    sc = $urandom_range(sc_lo, sc_hi);
    repeat (n) begin
      pick(qx, qy);
      if ($urandom_range(0, 49) == 0) sc = $urandom_range(sc_lo, sc_hi);
      cycle(0, $urandom_range(0, 3) != 0, frz_odds > 0 && $urandom_range(1, frz_odds) == 1, sc, qx, qy);
    end
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("rst_cnt", int'(active_cnt), 1);
    check("rst_frozen", int'(frozen), 0);
    check("rst_obj_px", int'(obj_px), 0);
    repeat (28) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 520, 380);
    cycle(0, 0, 0, 0, 519, 380);
    check("slot0_at_520", int'(obj_px), 1);
    check("slot0_rgb", int'(obj_rgb), 'h0A0);
    check("no_spawn_28", int'(active_cnt), 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("slot0_left_edge", int'(obj_px), 0);
    repeat (51) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("no_spawn_79", int'(active_cnt), 1);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 660, m_typ[1] != 0 ? 310 : 380);
    check("spawn_tick80", int'(active_cnt), 2);
    cycle(0, 0, 0, 0, 260, 380);
    check("spawn_at_660", int'(obj_px), 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("slot0_at_260", int'(obj_px), 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (10) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 660, 380);
    cycle(0, 0, 0, 0, 659, 380);
    check("frozen_set", int'(frozen), 1);
    check("frozen_x660", int'(obj_px), 1);
    check("frozen_cnt", int'(active_cnt), 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("frozen_x659", int'(obj_px), 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("reset_unfreeze", int'(frozen), 0);
    check("reset_cnt", int'(active_cnt), 1);
    run_random(4000, 300, 300, 0);
    run_random(3000, 0, 500, 0);
    cycle(0, 1, 1, 0, 0, 0);
    run_random(100, 0, 500, 0);
    cycle(1, 0, 0, 0, 0, 0);
    run_random(1500, 0, 400, 700);
    cycle(0, 0, 0, 0, 0, 0);
    @(negedge clk_rand);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/obstacle_field.md
# obstacle_field

Parametrised obstacle manager for the runner game: holds `N_SLOTS` scrolling obstacles, spawns new ones at LFSR-randomised gaps that tighten with score, freezes on collision, and answers per-pixel "is obstacle / colour" queries for the VGA compositor. It sits between the game-state FSM (which supplies `tick`, `freeze` and `score`) and the pixel mixer. It replaces the fixed 4-bean drawer.

## Interface
- `N_SLOTS`, 4: number of obstacle slots (2..8).
- `XW`, 12: signed width of obstacle x positions.
- `SHIFT`, 5: pixels scrolled per `tick`.
- `SPAWN_X`, 660: x at which new obstacles appear.
- `OBJ_W`, 20: obstacle width in pixels.
- `OBJ_H`, 30: obstacle height in pixels.
- `GROUND_Y`, 400: bottom y of floor obstacles.
- `FLY_Y`, 330: bottom y of flying obstacles.
- `GAP_START`, 400: initial minimum gap.
- `GAP_FLOOR`, 150: minimum-gap lower bound.
- `RANGE_START`, 150: initial jitter range.
- `RANGE_FLOOR`, 25: jitter-range lower bound.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `COL_FLOOR`, 12'h0A0; `COL_FLY`, 12'hA50: RGB444 colours.
- `clk_rand` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle scroll strobe, already in the `clk_rand` domain.
- `freeze` in 1: collision; level or pulse.
- `score` in 16: current score, unsigned.
- `px`, `py` in 10 each: pixel being drawn.
- `obj_px` out 1: pixel lies inside an active obstacle.
- `obj_rgb` out 12: colour of that obstacle; 0 when `obj_px`=0.
- `frozen` out 1: field is in the FROZEN state.
- `active_cnt` out 4: number of active slots.

## Operation
- Per-slot state: `active`, signed `pos[XW]`, `type` (0=floor, 1=flying).
- Global state: `last_pos` (signed x of the most recent spawn, scrolls with the field); `next_gap`; `min_gap`; `range`; `tick_par`; 16-bit Galois LFSR (taps 16,14,13,11).
- The LFSR advances every `clk_rand` cycle except during reset.
- FSM has two states, RUN and FROZEN:
  - RUN→FROZEN when `freeze`=1.
  - FROZEN is left only by `reset`.
  - In FROZEN, no scroll, no spawn, no parameter update; the pixel query stays live.
- On a `tick` in RUN:
  1. Every active slot does `pos -= SHIFT`. A slot whose new `pos` < −`OBJ_W` is cleared.
  2. `last_pos -= SHIFT`.
  3. `min_gap = max(GAP_FLOOR, GAP_START − score)`, using saturating unsigned subtract.
  4. `tick_par` toggles. When `tick_par` was 1 and `range` > `RANGE_FLOOR`, `range -= 1`.
  5. Spawn check: if `SPAWN_X − last_pos ≥ next_gap` and a slot was free before this tick, fill the lowest-index free slot:
     - `pos=SPAWN_X`, `type=lfsr[0]`, `last_pos=SPAWN_X`.
     - `next_gap = min_gap + ((lfsr[15:8]·range)>>8)`.
  6. At most one spawn per tick. If no slot is free, the spawn is deferred to a later tick.
- Pixel query:
  - A hit requires `pos ≤ px < pos+OBJ_W` (px zero-extended to `XW`).
  - It also requires `bottom−OBJ_H < py ≤ bottom`, where `bottom` is `GROUND_Y` or `FLY_Y` by type.
  - When several slots hit, the lowest index wins the colour.

## Timing
- Reset values:
  - Slot 0 active at `pos=SPAWN_X`, type floor; all other slots inactive.
  - `last_pos=SPAWN_X`, `next_gap=GAP_START`, `min_gap=GAP_START`, `range=RANGE_START`, `tick_par=0`, LFSR=`LFSR_SEED`, state RUN.
  - `obj_px=0`, `obj_rgb=0`, `frozen=0`, `active_cnt=1`.
- Scroll and spawn results are visible the cycle after the `tick` cycle.
- `obj_px`/`obj_rgb` are registered: 1-cycle latency from `px`/`py`.
- `frozen` asserts the cycle after `freeze`.
- Priority: `reset` > `freeze` > `tick`. A `tick` in the same cycle as `freeze` is discarded.
- A slot cleared on a tick is free for spawning from the next tick.
- Intermediate arithmetic is `XW+1` bits signed. `min_gap` and `next_gap` are 10 bits unsigned.

## Configuration
- `OBSTACLE_FLYING_EN` defined: `type=lfsr[0]`; flying obstacles and `COL_FLY` are used.
- `OBSTACLE_FLYING_EN` undefined:
  - `type` is forced to 0.
  - The per-slot type register and the flying y-band compare are not compiled.
  - Every spawn is a floor obstacle.

## Structure
- `goose_pkg` holds:
  - The `obj_type_e` enum (FLOOR, FLYING).
  - `GROUND_Y`, `FLY_Y`, `OBJ_W`, `OBJ_H`, and the RGB444 colour constants.
  - The shared LFSR tap mask.
- Sub-module `obstacle_lfsr`: 16-bit Galois LFSR with `seed` parameter and `en` input. It is reusable by the cloud/background spawner.

## Test plan
- Reset, then 28 ticks with score=0 → slot 0 at pos 520; `SPAWN_X−last_pos`=140 < 400, so no spawn; `active_cnt`=1.
- Reset, then 80 ticks → first spawn exactly on tick 80 (gap 400), in slot 1 at pos 660; `next_gap` lies in 400..549.
- Reset, then `tick` and `freeze` in the same cycle, then 10 more ticks → `frozen`=1 and slot 0 stays at 660. A further `reset` returns every register to its reset value.
- Set `score`=300 → `min_gap`=150 (clamped). After 500 ticks → `range`=25 and holds at 25.
- Fill all `N_SLOTS` with the gap condition met → no spawn. The spawn fires on the first tick after a slot retires below −20.
- Slot at pos 100, floor; query (px=110, py=380) → `obj_px`=1, `obj_rgb`=12'h0A0 one cycle later. Query (120, 380) → 0. Without `OBSTACLE_FLYING_EN`, all spawns report floor.
